// File: rtl/counter_load_ctrl_3bit_pkg.sv
// rtl/counter_load_ctrl_3bit_pkg.sv - shared state encoding and width defaults for the window controller
package counter_load_ctrl_3bit_pkg;

  localparam int WIDTH_DEF = 3;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/counter_load_ctrl_3bit_sat_counter.sv
// rtl/counter_load_ctrl_3bit_sat_counter.sv - saturating incrementer with synchronous clear
module counter_load_ctrl_3bit_sat_counter
  import counter_load_ctrl_3bit_pkg::*;
#(
  parameter int W = REP_W_DEF
) (
  input  logic         clk,
  input  logic         reset_al_in,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic [W-1:0] cnt_inc
);

  // Value the counter would take on an increment; sticks at all-ones.
  assign cnt_inc = (&cnt) ? cnt : cnt + W'(1);

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt_inc;
    end
  end

endmodule

// File: rtl/counter_up_3bit.sv
// rtl/counter_up_3bit.sv - 3-bit synchronous up-counter with synchronous parallel load
module counter_up_3bit (
  input  logic       clk,
  input  logic       reset_al_in,
  input  logic       load_in,
  input  logic [2:0] d_in,
  output logic [2:0] count_out
);

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      count_out <= 3'd0;
    end else if (load_in) begin
      count_out <= d_in;
    end else begin
      count_out <= count_out + 3'd1;
    end
  end

endmodule

// File: rtl/counter_load_ctrl_3bit.sv
// rtl/counter_load_ctrl_3bit.sv - drives counter load/data so it cycles a programmable start..end window
module counter_load_ctrl_3bit
  import counter_load_ctrl_3bit_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int REP_W = REP_W_DEF
) (
  input  logic             clk,
  input  logic             reset_al_in,
  input  logic             cfg_valid_in,
  output logic             cfg_ready_out,
  input  logic [WIDTH-1:0] cfg_start_in,
  input  logic [WIDTH-1:0] cfg_end_in,
  input  logic [REP_W-1:0] cfg_reps_in,
  input  logic             abort_in,
  input  logic [WIDTH-1:0] count_in,
  output logic             load_out,
  output logic [WIDTH-1:0] d_out,
  output logic             wrap_out,
  output logic             busy_out,
  output logic             done_out,
  output logic [REP_W-1:0] wrap_cnt_out
);

  state_t           state;
  logic [WIDTH-1:0] start_reg;
  logic [WIDTH-1:0] end_reg;
  logic [REP_W-1:0] reps_reg;
  logic [REP_W-1:0] wrap_cnt_inc;
  logic             cfg_accept;
  logic             at_end;
  logic             reps_hit;

  assign cfg_accept = cfg_valid_in && (state == ST_IDLE);
  assign at_end     = (count_in == end_reg);
  // Judged on the post-increment wrap count so the final wrap itself ends the run.
  assign reps_hit   = (reps_reg != '0) && (wrap_cnt_inc == reps_reg);

  always_comb begin
    cfg_ready_out = 1'b0;
    load_out      = 1'b1;
    d_out         = start_reg;
    wrap_out      = 1'b0;
    case (state)
      ST_IDLE: cfg_ready_out = 1'b1;
      ST_RUN: begin
        wrap_out = at_end;
        load_out = at_end || abort_in;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_al_in) begin
    if (!reset_al_in) begin
      state     <= ST_IDLE;
      start_reg <= '0;
      end_reg   <= '1;
      reps_reg  <= '0;
      busy_out  <= 1'b0;
      done_out  <= 1'b0;
    end else begin
      busy_out <= 1'b0;
      done_out <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cfg_valid_in) begin
            start_reg <= cfg_start_in;
            end_reg   <= cfg_end_in;
            reps_reg  <= cfg_reps_in;
            state     <= ST_PRIME;
            busy_out  <= 1'b1;
          end
        end
        ST_PRIME: begin
          if (abort_in) begin
            state <= ST_IDLE;
          end else begin
            state    <= ST_RUN;
            busy_out <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort_in) begin
            state <= ST_IDLE;
          end else if (at_end && reps_hit) begin
            state    <= ST_DONE;
            done_out <= 1'b1;
          end else begin
            busy_out <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  counter_load_ctrl_3bit_sat_counter #(.W(REP_W)) u_wrap_cnt (
    .clk        (clk),
    .reset_al_in(reset_al_in),
    .clr        (cfg_accept),
    .inc        (wrap_out),
    .cnt        (wrap_cnt_out),
    .cnt_inc    (wrap_cnt_inc)
  );

endmodule

// File: doc/counter_load_ctrl_3bit.md
Name: counter_load_ctrl_3bit

Overview:
Upstream controller for the 3-bit synchronous up-counter (counter_up_3bit). It drives the counter's load_in and d_in from count_out so the counter runs a programmable window from start to end, with optional wrap-around through 7->0. The window is programmed through a valid/ready config handshake. Supports free-running and N-repetition (one-shot) operation, abort, and a wrap count.

Parameters:
WIDTH, 3, counter data width; must match the counter (3).
REP_W, 4, width of the repetition count and of the wrap counter.

Ports:
clk  input  1  rising-edge clock, shared with the counter
reset_al_in  input  1  asynchronous active-low reset, shared with the counter
cfg_valid_in  input  1  config request
cfg_ready_out  output  1  config accepted when valid && ready at the clock edge
cfg_start_in  input  WIDTH  window start value
cfg_end_in  input  WIDTH  window end value (terminal count)
cfg_reps_in  input  REP_W  0 = run forever; N>0 = stop after N wraps
abort_in  input  1  stop the run, return to IDLE
count_in  input  WIDTH  counter's count_out
load_out  output  1  to counter load_in
d_out  output  WIDTH  to counter d_in
wrap_out  output  1  high in the cycle count_in==end while RUN (the cycle the reload is issued)
busy_out  output  1  registered; high in PRIME/RUN
done_out  output  1  registered; one-cycle pulse on completion of N reps
wrap_cnt_out  output  REP_W  wraps since last config accept; saturates at all-ones

Behaviour:
- Clock and reset: single clock. Reset is asynchronous and active-low (reset_al_in).
- Reset values: state=IDLE, start_reg=0, end_reg=7, reps_reg=0, wrap_cnt_out=0, busy_out=0, done_out=0.
- Combinational during reset (IDLE): load_out=1, d_out=0, cfg_ready_out=1, wrap_out=0.
- States are IDLE, PRIME, RUN, DONE.
- IDLE:
  - cfg_ready_out=1; load_out=1, d_out=start_reg, so the counter is held at start.
  - On accept: capture start/end/reps, clear wrap_cnt, go to PRIME.
- PRIME (1 cycle):
  - load_out=1, d_out=start_reg; go to RUN. busy_out rises on the edge into PRIME.
  - Counter equals start on the first RUN cycle.
- RUN:
  - load_out=0 while count_in != end_reg; the counter increments naturally, wrapping 7->0 with no action.
  - When count_in==end_reg: load_out=1, d_out=start_reg, wrap_out=1. wrap_cnt increments (saturating) on that edge.
  - Period = ((end-start) mod 8)+1 cycles. start==end gives wrap_out every cycle.
  - If reps_reg!=0 and this wrap makes wrap_cnt==reps_reg: go to DONE.
- DONE (1 cycle):
  - load_out=1, d_out=start_reg; done_out=1 during DONE (registered); then IDLE.
- load_out, d_out, wrap_out and cfg_ready_out are combinational from state, count_in and the registers.
- cfg_ready_out=0 in PRIME/RUN/DONE; cfg_valid_in is ignored there and config is not captured.
- abort_in:
  - In PRIME/RUN: the next state is IDLE; load_out=1, d_out=start_reg that cycle; no done pulse; wrap_cnt holds.
  - abort_in has priority over a wrap in the same cycle: wrap_out still asserts, wrap_cnt increments, but the next state is IDLE, not DONE.
  - Ignored in IDLE/DONE.
- Simultaneous cfg accept and abort in IDLE: the accept wins.
- Reset mid-operation: immediate return to the reset values above. The counter is reset by the same signal.
- Width rules:
  - Equality compare on WIDTH bits; no arithmetic on count.
  - wrap_cnt is REP_W bits, saturates at 2^REP_W-1.
  - reps compare uses a full REP_W equality.

Decomposition:
- Shared package: state encoding constants (ST_IDLE=2'd0, ST_PRIME=2'd1, ST_RUN=2'd2, ST_DONE=2'd3) and the WIDTH default.
- One natural sub-module: sat_counter (REP_W-bit saturating incrementer with synchronous clear and asynchronous active-low reset), used for wrap_cnt.
- The bench instantiates counter_up_3bit alongside counter_load_ctrl_3bit, with the loop closed.

Test Plan:
1. Free-running window: start=2, end=5, reps=0, accepted at edge E0.
   - PRIME after E0; count_in=2,3,4,5,2,3,…; wrap_out high whenever count=5.
   - wrap_cnt_out=3 after 3 wraps; busy_out=1 throughout.
2. Wrap-around window: start=6, end=1, reps=0.
   - Count sequence 6,7,0,1,6,…; period 4; load_out only at count=1.
3. Degenerate window: start=end=3.
   - Count stays 3; wrap_out high every RUN cycle; wrap_cnt saturates at 15 and holds.
4. One-shot run: start=0, end=2, reps=2.
   - Count 0,1,2,0,1,2; after the 2nd wrap, DONE with done_out one cycle; IDLE holds count=0.
   - cfg_ready_out returns to 1; wrap_cnt_out=2.
5. Abort and ignored config: start=4, end=7, reps=0.
   - cfg_valid_in pulsed during RUN with start=1 is ignored (ready=0).
   - abort_in at count=5 -> load start=4; IDLE; count held at 4; done_out stays 0.
6. Reset mid-run: reset_al_in low asynchronously mid-run.
   - Outputs immediately at reset values, counter=0, end_reg=7.
   - After release, IDLE with load_out=1, d_out=0.
